pe_mult_scheduler: RTL and testbench
====================================

# pe_mult_scheduler

Round-robin scheduler that shares one registered N×N unsigned multiplier among NREQ requesters inside the floating-point systolic PE, typically the mantissa-multiply clients of neighbouring PEs. It arbitrates valid/ready requests, latches the winner's operands, sequences the one-cycle multiplier, and returns the full 2N-bit product to the originating requester with a per-requester response handshake.

## Interface
- `N`, 5: operand width in bits. The product is 2N bits.
- `NREQ`, 4: number of requesters, 2..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_a`  in  NREQ*N  operand A, packed; slice i is bits [i*N +: N].
- `req_b`  in  NREQ*N  operand B, packed the same way.
- `req_ready`  out  NREQ  request accepted this cycle; at most one bit is set.
- `rsp_valid`  out  NREQ  product available for requester i; at most one bit is set.
- `rsp_ready`  in  NREQ  requester i consumes the response.
- `rsp_p`  out  2N  product, shared bus; meaningful only while a `rsp_valid` bit is set.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching upward from `rr_ptr` and wrapping modulo NREQ.
  - `req_ready[winner]` = 1, driven combinationally from `req_valid` and `rr_ptr`.
  - On that cycle's edge: latch `op_a`/`op_b` from slice `winner`, set `owner` = winner, set `rr_ptr` = (winner+1) mod NREQ, go to MUL.
  - If no `req_valid` bit is set, stay in IDLE; `rr_ptr` is unchanged.
- MUL: the multiplier samples `op_a`/`op_b` and registers the product. Always go to RESP.
- RESP:
  - `rsp_valid[owner]` = 1; `rsp_p` holds the registered product, stable.
  - Stay in RESP while `rsp_ready[owner]` = 0.
  - On `rsp_ready[owner]` = 1, go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- Arithmetic: `rsp_p` = `op_a` × `op_b`, unsigned, full 2N bits, never truncated. Maximum for N=5 is 31×31 = 961.
- Requester rules:
  - `req_valid` may not drop, and `req_a`/`req_b` may not change, until `req_ready` is seen.
  - The scheduler takes operands only in the accept cycle; later changes to slice inputs do not affect the product.
- `req_ready` is 0 in MUL and RESP. No new request is accepted until the response handshake completes.
- Fairness: a requester holding `req_valid` is granted within NREQ grants.
- Reset, asserted at any time and in any state:
  - State goes to IDLE, `rr_ptr` to 0, `owner` to 0, the product register to 0.
  - An in-flight transaction is dropped and no response is ever issued for it.
- Outputs during and right after reset: `req_ready` follows the IDLE arbitration rule; `rsp_valid` = 0, `rsp_p` = 0, `busy` = 0.

## Timing
- Accept handshake in cycle T (`req_valid & req_ready`).
- T+1: state MUL, `busy` = 1.
- T+2: `rsp_valid[owner]` = 1 with the correct `rsp_p`. Latency is 2 cycles from accept to response.
- If `rsp_ready` is high at T+2, the state is IDLE at T+3 and the next accept can happen at T+3. Peak throughput is one product per 3 cycles.
- Each extra cycle of `rsp_ready` low adds exactly one cycle of latency; `rsp_p` and `rsp_valid` hold steady while it is low.
- Simultaneous requests are resolved in a single cycle with no bubble; losing requesters keep `req_valid` asserted.
- `busy` is registered, derived from state.

## Structure
- Package `pe_mult_pkg` holds:
  - the state encoding (IDLE = 0, MUL = 1, RESP = 2, 2 bits);
  - an index-width constant/function (clog2 of NREQ, minimum 1).
- Sub-module `pe_mult_core`: registered N×N unsigned multiplier. Ports are `clk`, `rst_n`, `a`, `b`, `p`; p is updated every clock edge.
- The scheduler contains the FSM, round-robin pointer, operand/owner registers and output decode. It instantiates one `pe_mult_core`.

## Test plan
- Single request: req0 with a=31, b=31 → `req_ready[0]` same cycle; `rsp_valid[0]` and `rsp_p`=961 two cycles later; with `rsp_ready[0]` high, `busy` = 0 the next cycle.
- All four requesters valid continuously from reset, rsp_ready held high → grants in order 0,1,2,3,0 at 3-cycle spacing; products match a=i+1, b=2i+3 for each i.
- Backpressure: req2 with a=7, b=9, `rsp_ready[2]` low for 5 cycles → `rsp_p`=63 held stable; no `req_ready` during the stall even with req1 valid; req1 is granted the cycle after release.
- Wrong-owner ready: req1 in RESP with only `rsp_ready[3]` high → state stays RESP, `rsp_valid[1]` stays high.
- Reset mid-operation: drop `rst_n` in MUL → `rsp_valid` = 0 immediately and stays 0; after release, `rr_ptr` = 0 and requester 0 wins a tie with requester 3.
- Zero/edge operands: a=0, b=31 → 0; a=1, b=31 → 31; a=16, b=16 → 256. No truncation of any 10-bit result.

Source files
------------

// File: rtl/pe_mult_pkg.sv
// Shared types and sizing helpers for the PE multiplier scheduler.
package pe_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a requester count; a single bit is the floor even for tiny NREQ.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_mult_core.sv
// Registered N x N unsigned multiplier; the full 2N-bit product updates every clock edge.
module pe_mult_core #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] b_ext;

  assign a_ext = {{N{1'b0}}, a};
  assign b_ext = {{N{1'b0}}, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= a_ext * b_ext;
  end

endmodule

// File: rtl/pe_mult_scheduler.sv
// Round-robin arbiter sharing one registered multiplier among NREQ requesters,
// returning each product on a shared bus with a per-requester response handshake.
module pe_mult_scheduler
  import pe_mult_pkg::*;
#(
  parameter int N    = 5,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*N-1:0]    rsp_p,
  output logic              busy
);

  localparam int IW = idx_width(NREQ);

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   next_ptr;
  logic            grant_found;
  logic            accept;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [2*N-1:0]  prod;

  // Search upward from rr_ptr with wraparound; the first valid requester wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  assign next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  assign accept   = (state == IDLE) && grant_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_found) next_state = MUL;
      MUL:     next_state = RESP;
      RESP:    if (rsp_ready[owner]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured only on the accept edge, so later slice changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
      owner  <= grant_idx;
      op_a   <= req_a[int'(grant_idx)*N +: N];
      op_b   <= req_b[int'(grant_idx)*N +: N];
    end
  end

  pe_mult_core #(.N(N)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (op_a),
    .b     (op_b),
    .p     (prod)
  );

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_p     = '0;
    case (state)
      IDLE: if (grant_found) req_ready[grant_idx] = 1'b1;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        rsp_p            = prod;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_mult_scheduler.sv
// Directed bench for pe_mult_scheduler: arbitration order, latency, backpressure, reset and operand edges.
module tb_pe_mult_scheduler;

  localparam int N    = 5;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2*N-1:0]    rsp_p;
  logic              busy;

  int n_checks;
  int n_fail;

  pe_mult_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    tick; tick;
    req_valid = 4'b1000;
    #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_rsp_p: got %0d want 0", rsp_p); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL reset_req_ready_arb: got %b want 1000", req_ready); end
    req_valid = '0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_req_ready_idle: got %b want 0000", req_ready); end
    rst_n = 1'b1;
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    req_valid = 4'b0001; req_a[0 +: N] = 5'd31; req_b[0 +: N] = 5'd31; rsp_ready = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready: got %b want 0001", req_ready); end
    tick; req_valid = '0; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_mul: got %b want 1", busy); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_no_early_rsp: got %b want 0000", rsp_valid); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_ready_mul: got %b want 0000", req_ready); end
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd961) begin n_fail++; $display("[TB] FAIL single_rsp_p: got %0d want 961", rsp_p); end
    tick; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_after: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_rsp_cleared: got %b want 0000", rsp_valid); end
    rsp_ready = '0;
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_bit;
    logic [2*N-1:0]  exp_p;
    int i;
    rst_n = 1'b0;
    tick;
    for (int r = 0; r < NREQ; r++) begin
      req_a[r*N +: N] = N'(r + 1);
      req_b[r*N +: N] = N'(2*r + 3);
    end
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      i       = g % NREQ;
      exp_bit = NREQ'(1) << i;
      exp_p   = 10'((i + 1) * (2*i + 3));
      n_checks++; if (req_ready !== exp_bit) begin n_fail++; $display("[TB] FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_bit); end
      tick; #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr_ready_mul%0d: got %b want 0000", g, req_ready); end
      tick; #1;
      n_checks++; if (rsp_valid !== exp_bit) begin n_fail++; $display("[TB] FAIL rr_rsp_valid%0d: got %b want %b", g, rsp_valid, exp_bit); end
      n_checks++; if (rsp_p !== exp_p) begin n_fail++; $display("[TB] FAIL rr_rsp_p%0d: got %0d want %0d", g, rsp_p, exp_p); end
      tick; #1;
    end
    req_valid = '0; rsp_ready = '0;
  endtask

  task automatic test_backpressure;
    req_valid = 4'b0100; req_a[2*N +: N] = 5'd7; req_b[2*N +: N] = 5'd9; rsp_ready = '0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_grant2: got %b want 0100", req_ready); end
    tick;
    req_valid = 4'b0010; req_a[1*N +: N] = 5'd3; req_b[1*N +: N] = 5'd5;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_ready_mul: got %b want 0000", req_ready); end
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_rsp_valid: got %b want 0100", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd63) begin n_fail++; $display("[TB] FAIL bp_rsp_p: got %0d want 63", rsp_p); end
    for (int s = 0; s < 4; s++) begin
      tick; #1;
      n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_hold_valid%0d: got %b want 0100", s, rsp_valid); end
      n_checks++; if (rsp_p !== 10'd63) begin n_fail++; $display("[TB] FAIL bp_hold_p%0d: got %0d want 63", s, rsp_p); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_stall_ready%0d: got %b want 0000", s, req_ready); end
    end
    tick; rsp_ready = 4'b0100; #1;
    n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_release_valid: got %b want 0100", rsp_valid); end
    tick; rsp_ready = '0; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_grant1_after: got %b want 0010", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_busy_idle: got %b want 0", busy); end
    tick; req_valid = '0; #1;
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_req1_valid: got %b want 0010", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd15) begin n_fail++; $display("[TB] FAIL bp_req1_p: got %0d want 15", rsp_p); end
    rsp_ready = 4'b0010;
    tick; rsp_ready = '0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrong_owner;
    req_valid = 4'b0010; req_a[1*N +: N] = 5'd6; req_b[1*N +: N] = 5'd4; rsp_ready = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL wo_grant: got %b want 0010", req_ready); end
    tick; req_valid = '0; #1;
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL wo_rsp_valid: got %b want 0010", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd24) begin n_fail++; $display("[TB] FAIL wo_rsp_p: got %0d want 24", rsp_p); end
    for (int s = 0; s < 3; s++) begin
      tick; #1;
      n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL wo_hold_valid%0d: got %b want 0010", s, rsp_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wo_hold_busy%0d: got %b want 1", s, busy); end
    end
    rsp_ready = 4'b0010;
    tick; rsp_ready = '0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wo_done_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL wo_done_valid: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b0001; req_a[0 +: N] = 5'd5; req_b[0 +: N] = 5'd5; rsp_ready = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rm_grant0: got %b want 0001", req_ready); end
    tick; req_valid = '0; #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_busy_mul: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL rm_rsp_valid_now: got %b want 0000", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_busy_now: got %b want 0", busy); end
    n_checks++; if (rsp_p !== 10'd0) begin n_fail++; $display("[TB] FAIL rm_rsp_p_now: got %0d want 0", rsp_p); end
    tick;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL rm_rsp_valid_held: got %b want 0000", rsp_valid); end
    req_valid = 4'b1001;
    req_a[0 +: N] = 5'd2; req_b[0 +: N] = 5'd3;
    req_a[3*N +: N] = 5'd4; req_b[3*N +: N] = 5'd4;
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rm_tie_winner: got %b want 0001", req_ready); end
    tick; req_valid = 4'b1000; #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL rm_no_stale_rsp: got %b want 0000", rsp_valid); end
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("[TB] FAIL rm_rsp0_valid: got %b want 0001", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd6) begin n_fail++; $display("[TB] FAIL rm_rsp0_p: got %0d want 6", rsp_p); end
    tick; #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL rm_grant3: got %b want 1000", req_ready); end
    tick; req_valid = '0; #1;
    tick; #1;
    n_checks++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("[TB] FAIL rm_rsp3_valid: got %b want 1000", rsp_valid); end
    n_checks++; if (rsp_p !== 10'd16) begin n_fail++; $display("[TB] FAIL rm_rsp3_p: got %0d want 16", rsp_p); end
    tick; rsp_ready = '0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_edge_operands;
    logic [N-1:0]    ta [4];
    logic [N-1:0]    tb [4];
    logic [2*N-1:0]  tp [4];
    logic [NREQ-1:0] exp_bit;
    ta = '{5'd0, 5'd1, 5'd16, 5'd31};
    tb = '{5'd31, 5'd31, 5'd16, 5'd30};
    tp = '{10'd0, 10'd31, 10'd256, 10'd930};
    for (int t = 0; t < 4; t++) begin
      exp_bit = NREQ'(1) << t;
      req_a[t*N +: N] = ta[t]; req_b[t*N +: N] = tb[t];
      req_valid = exp_bit; rsp_ready = 4'b1111;
      #1;
      n_checks++; if (req_ready !== exp_bit) begin n_fail++; $display("[TB] FAIL edge_grant%0d: got %b want %b", t, req_ready, exp_bit); end
      tick; req_valid = '0; #1;
      tick; #1;
      n_checks++; if (rsp_valid !== exp_bit) begin n_fail++; $display("[TB] FAIL edge_valid%0d: got %b want %b", t, rsp_valid, exp_bit); end
      n_checks++; if (rsp_p !== tp[t]) begin n_fail++; $display("[TB] FAIL edge_p%0d: got %0d want %0d", t, rsp_p, tp[t]); end
      tick; #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_busy%0d: got %b want 0", t, busy); end
    end
    rsp_ready = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_wrong_owner;
    test_reset_mid;
    test_edge_operands;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
